// File: rtl/cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
//
// Flag-consuming end of the ALU interface in the execute stage. It holds the
// architectural NZCV register and evaluates the 4-bit ARM condition field
// against it. It gates the instruction's register, memory and PC side effects,
// and registers the gated controls plus the ALU result into the next stage.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears flags and pipeline state
//   in_valid      execute-stage instruction valid
//   stall         hold all state (flags and pipeline register)
//   flush         kill the current instruction; overrides stall
//   cond          ARM condition field
//   flag_w        [1] write N,Z  [0] write C,V
//   alu_result    ALU result (N bits)
//   cv_flags      {C,V} produced by the ALU
//   reg_write_in  decoded register write
//   mem_write_in  decoded memory write
//   pc_src_in     decoded PC write / branch
//   carry         stored C flag, fed back to the ALU carry input
//   flags         architectural {N,Z,C,V}
//   cond_ex       condition result against the current (pre-update) flags
//   out_valid     registered stage-output valid
//   reg_write     registered, gated register write
//   mem_write     registered, gated memory write
//   pc_src        registered, gated PC write
//   result_q      registered ALU result
// -----------------------------------------------------------------------------
module cond_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         stall,
    input  logic         flush,
    input  logic [3:0]   cond,
    input  logic [1:0]   flag_w,
    input  logic [N-1:0] alu_result,
    input  logic [1:0]   cv_flags,
    input  logic         reg_write_in,
    input  logic         mem_write_in,
    input  logic         pc_src_in,
    output logic         carry,
    output logic [3:0]   flags,
    output logic         cond_ex,
    output logic         out_valid,
    output logic         reg_write,
    output logic         mem_write,
    output logic         pc_src,
    output logic [N-1:0] result_q
);

    // Bit positions inside the {N,Z,C,V} register.
    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    // Evaluate an ARM condition code against a flag set. Code 4'b1111 is
    // treated as "never".
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic res;
        n  = f[FN];
        z  = f[FZ];
        cy = f[FC];
        v  = f[FV];
        case (c)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = cy;
            4'b0011: res = ~cy;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = cy & ~z;
            4'b1001: res = ~cy | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Build the candidate {N,Z,C,V} from the ALU outputs.
    function automatic logic [3:0] derive_flags(input logic [N-1:0] r,
                                                input logic [1:0]   cv);
        logic [3:0] nf;
        nf[FN] = r[N-1];
        nf[FZ] = (r == '0);
        nf[FC] = cv[1];
        nf[FV] = cv[0];
        return nf;
    endfunction

    logic [3:0]   flags_q,     flags_d;
    logic         out_valid_q, out_valid_d;
    logic         reg_write_q, reg_write_d;
    logic         mem_write_q, mem_write_d;
    logic         pc_src_q,    pc_src_d;
    logic [N-1:0] result_q_q,  result_q_d;

    logic         fire;
    logic         cond_pass;
    logic         advance;
    logic [3:0]   new_flags;

    assign cond_pass = eval_cond(cond, flags_q);
    assign new_flags = derive_flags(alu_result, cv_flags);
    assign fire      = in_valid & ~stall & ~flush;
    // The pipeline register moves on any non-stalled cycle; a flush also
    // moves it (to a bubble) even while stalled, since flush wins over stall.
    assign advance   = ~stall | flush;

    // Next-state: flag register. Each half writes independently and only
    // when the instruction actually fires and its condition passes.
    always_comb begin
        flags_d = flags_q;
        if (fire && cond_pass) begin
            if (flag_w[1]) begin
                flags_d[FN] = new_flags[FN];
                flags_d[FZ] = new_flags[FZ];
            end
            if (flag_w[0]) begin
                flags_d[FC] = new_flags[FC];
                flags_d[FV] = new_flags[FV];
            end
        end
    end

    // Next-state: pipeline register. A bubble or flush clears valid and the
    // controls but leaves result_q untouched; a stall holds everything.
    always_comb begin
        out_valid_d = out_valid_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        pc_src_d    = pc_src_q;
        result_q_d  = result_q_q;
        if (fire) begin
            out_valid_d = 1'b1;
            reg_write_d = reg_write_in & cond_pass;
            mem_write_d = mem_write_in & cond_pass;
            pc_src_d    = pc_src_in    & cond_pass;
            result_q_d  = alu_result;
        end else if (advance) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            pc_src_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            result_q_q  <= '0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            pc_src_q    <= pc_src_d;
            result_q_q  <= result_q_d;
        end
    end

    assign flags     = flags_q;
    assign carry     = flags_q[FC];
    assign cond_ex   = cond_pass;
    assign out_valid = out_valid_q;
    assign reg_write = reg_write_q;
    assign mem_write = mem_write_q;
    assign pc_src    = pc_src_q;
    assign result_q  = result_q_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed testbench for cond_unit.
module tb_cond_unit;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, stall, flush;
    logic [3:0]   cond;
    logic [1:0]   flag_w;
    logic [N-1:0] alu_result;
    logic [1:0]   cv_flags;
    logic         reg_write_in, mem_write_in, pc_src_in;
    logic         carry;
    logic [3:0]   flags;
    logic         cond_ex;
    logic         out_valid, reg_write, mem_write, pc_src;
    logic [N-1:0] result_q;

    int n_cmp = 0;
    int n_err = 0;

    cond_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .cond(cond), .flag_w(flag_w), .alu_result(alu_result), .cv_flags(cv_flags),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .pc_src_in(pc_src_in),
        .carry(carry), .flags(flags), .cond_ex(cond_ex), .out_valid(out_valid),
        .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src), .result_q(result_q)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] c,
                         input logic [1:0] fw, input logic [N-1:0] r, input logic [1:0] cv,
                         input logic rw, input logic mw, input logic pc);
        in_valid = v; stall = st; flush = fl; cond = c; flag_w = fw;
        alu_result = r; cv_flags = cv; reg_write_in = rw; mem_write_in = mw; pc_src_in = pc;
    endtask

    // Advance one clock edge; outputs are then observed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 4'hE, 2'b11, 32'h0, 2'b11, 1, 1, 1);
        tick();
        n_cmp++; if (flags !== 4'b0111) begin n_err++; $display("FAIL rst_pre_flags got=%b exp=0111", flags); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
        n_cmp++; if ({reg_write, mem_write, pc_src} !== 3'b111) begin n_err++; $display("FAIL rst_pre_ctl got=%b exp=111", {reg_write, mem_write, pc_src}); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", flags); end
        n_cmp++; if (carry !== 1'b0) begin n_err++; $display("FAIL rst_carry got=%b exp=0", carry); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if ({reg_write, mem_write, pc_src} !== 3'b000) begin n_err++; $display("FAIL rst_ctl got=%b exp=000", {reg_write, mem_write, pc_src}); end
        n_cmp++; if (result_q !== 32'h0) begin n_err++; $display("FAIL rst_result got=%h exp=0", result_q); end
        // Held across an edge with a firing instruction: nothing may load.
        drive(1, 0, 0, 4'hE, 2'b11, 32'h8000_0001, 2'b11, 1, 1, 1);
        tick();
        n_cmp++; if ({flags, out_valid, reg_write} !== 6'b0) begin n_err++; $display("FAIL rst_hold got=%b exp=000000", {flags, out_valid, reg_write}); end
        #2 reset = 1'b0;
        drive(0, 0, 0, 4'hE, 2'b00, 32'h0, 2'b00, 0, 0, 0);
        tick();
    endtask

    task automatic test_subs_beq();
        logic [15:0] exp_tab;
        // SUBS producing zero with carry set.
        drive(1, 0, 0, 4'hE, 2'b11, 32'h0, 2'b10, 0, 0, 0);
        #1;
        n_cmp++; if (cond_ex !== 1'b1) begin n_err++; $display("FAIL subs_condex got=%b exp=1", cond_ex); end
        tick();
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL subs_flags got=%b exp=0110", flags); end
        n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL subs_carry got=%b exp=1", carry); end
        // BEQ right behind it.
        drive(1, 0, 0, 4'h0, 2'b00, 32'h5, 2'b00, 0, 0, 1);
        #1;
        n_cmp++; if (cond_ex !== 1'b1) begin n_err++; $display("FAIL beq_condex got=%b exp=1", cond_ex); end
        tick();
        n_cmp++; if (pc_src !== 1'b1) begin n_err++; $display("FAIL beq_pcsrc got=%b exp=1", pc_src); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid got=%b exp=1", out_valid); end
        n_cmp++; if (result_q !== 32'h5) begin n_err++; $display("FAIL beq_result got=%h exp=5", result_q); end
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL beq_flags got=%b exp=0110", flags); end
        // Full condition table against flags 0110 (bit i = expected for cond i).
        exp_tab = 16'h66A5;
        drive(0, 0, 0, 4'h0, 2'b11, 32'h0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            n_cmp++; if (cond_ex !== exp_tab[i]) begin n_err++; $display("FAIL tab0110_c%0d got=%b exp=%b", i, cond_ex, exp_tab[i]); end
        end
        tick();
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL invalid_nowrite got=%b exp=0110", flags); end
    endtask

    task automatic test_failed_cond();
        drive(1, 0, 0, 4'hE, 2'b11, 32'h1, 2'b00, 0, 0, 0);
        tick();
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL fc_setup got=%b exp=0000", flags); end
        drive(1, 0, 0, 4'h0, 2'b11, 32'h8000_0000, 2'b11, 1, 0, 0);
        #1;
        n_cmp++; if (cond_ex !== 1'b0) begin n_err++; $display("FAIL fc_condex got=%b exp=0", cond_ex); end
        tick();
        n_cmp++; if (reg_write !== 1'b0) begin n_err++; $display("FAIL fc_regwrite got=%b exp=0", reg_write); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fc_valid got=%b exp=1", out_valid); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL fc_flags got=%b exp=0000", flags); end
        n_cmp++; if (result_q !== 32'h8000_0000) begin n_err++; $display("FAIL fc_result got=%h exp=80000000", result_q); end
    endtask

    task automatic test_partial_write();
        logic [15:0] exp_tab;
        drive(1, 0, 0, 4'hE, 2'b11, 32'h1, 2'b11, 0, 0, 0);
        tick();
        n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL pw_setup got=%b exp=0011", flags); end
        drive(1, 0, 0, 4'hE, 2'b10, 32'h8000_0000, 2'b00, 0, 0, 0);
        tick();
        n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL pw_nz_only got=%b exp=1011", flags); end
        drive(0, 0, 0, 4'hA, 2'b00, 32'h0, 2'b00, 0, 0, 0);
        #1;
        n_cmp++; if (cond_ex !== 1'b1) begin n_err++; $display("FAIL pw_ge got=%b exp=1", cond_ex); end
        cond = 4'hC;
        #1;
        n_cmp++; if (cond_ex !== 1'b1) begin n_err++; $display("FAIL pw_gt got=%b exp=1", cond_ex); end
        exp_tab = 16'h5556;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            n_cmp++; if (cond_ex !== exp_tab[i]) begin n_err++; $display("FAIL tab1011_c%0d got=%b exp=%b", i, cond_ex, exp_tab[i]); end
        end
        // C,V-only write keeps N,Z.
        drive(1, 0, 0, 4'hE, 2'b01, 32'h0, 2'b01, 0, 0, 0);
        tick();
        n_cmp++; if (flags !== 4'b1001) begin n_err++; $display("FAIL pw_cv_only got=%b exp=1001", flags); end
        drive(1, 0, 0, 4'hE, 2'b01, 32'h0, 2'b11, 0, 0, 0);
        tick();
        n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL pw_restore got=%b exp=1011", flags); end
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 0, 4'hE, 2'b00, 32'h1234, 2'b00, 1, 0, 0);
        tick();
        n_cmp++; if ({out_valid, reg_write, result_q} !== {2'b11, 32'h1234}) begin n_err++; $display("FAIL sf_setup got=%b%b %h exp=11 1234", out_valid, reg_write, result_q); end
        drive(1, 1, 0, 4'hE, 2'b11, 32'h0, 2'b00, 0, 1, 1);
        tick();
        tick();
        n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL stall_flags got=%b exp=1011", flags); end
        n_cmp++; if ({out_valid, reg_write, mem_write, pc_src} !== 4'b1100) begin n_err++; $display("FAIL stall_ctl got=%b exp=1100", {out_valid, reg_write, mem_write, pc_src}); end
        n_cmp++; if (result_q !== 32'h1234) begin n_err++; $display("FAIL stall_result got=%h exp=1234", result_q); end
        n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL stall_carry got=%b exp=1", carry); end
        drive(1, 1, 1, 4'hE, 2'b11, 32'h0, 2'b00, 1, 1, 1);
        tick();
        n_cmp++; if ({out_valid, reg_write, mem_write, pc_src} !== 4'b0000) begin n_err++; $display("FAIL stallflush_ctl got=%b exp=0000", {out_valid, reg_write, mem_write, pc_src}); end
        n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL stallflush_flags got=%b exp=1011", flags); end
        n_cmp++; if (result_q !== 32'h1234) begin n_err++; $display("FAIL stallflush_result got=%h exp=1234", result_q); end
        drive(1, 0, 1, 4'hE, 2'b11, 32'h0, 2'b00, 1, 0, 0);
        tick();
        n_cmp++; if ({flags, out_valid, reg_write} !== 6'b101100) begin n_err++; $display("FAIL flush_only got=%b exp=101100", {flags, out_valid, reg_write}); end
        drive(0, 0, 0, 4'hE, 2'b11, 32'h0, 2'b00, 1, 1, 1);
        tick();
        n_cmp++; if ({flags, out_valid, reg_write, mem_write, pc_src} !== 8'b10110000) begin n_err++; $display("FAIL bubble got=%b exp=10110000", {flags, out_valid, reg_write, mem_write, pc_src}); end
    endtask

    task automatic test_never();
        drive(1, 0, 0, 4'hF, 2'b11, 32'h0, 2'b00, 1, 1, 1);
        #1;
        n_cmp++; if (cond_ex !== 1'b0) begin n_err++; $display("FAIL nv_condex got=%b exp=0", cond_ex); end
        tick();
        n_cmp++; if ({reg_write, mem_write, pc_src} !== 3'b000) begin n_err++; $display("FAIL nv_ctl got=%b exp=000", {reg_write, mem_write, pc_src}); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL nv_valid got=%b exp=1", out_valid); end
        n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL nv_flags got=%b exp=1011", flags); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 4'hE, 2'b11, 32'h0, 2'b00, 0, 0, 0);
        tick();
        n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL b2b_first got=%b exp=0100", flags); end
        drive(1, 0, 0, 4'h0, 2'b01, 32'h7, 2'b10, 0, 1, 0);
        #1;
        n_cmp++; if (cond_ex !== 1'b1) begin n_err++; $display("FAIL b2b_eq got=%b exp=1", cond_ex); end
        tick();
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL b2b_second got=%b exp=0110", flags); end
        n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL b2b_memwrite got=%b exp=1", mem_write); end
        drive(1, 0, 0, 4'h1, 2'b11, 32'h9, 2'b01, 1, 0, 0);
        #1;
        n_cmp++; if (cond_ex !== 1'b0) begin n_err++; $display("FAIL b2b_ne got=%b exp=0", cond_ex); end
        tick();
        n_cmp++; if ({flags, reg_write, mem_write} !== 6'b011000) begin n_err++; $display("FAIL b2b_third got=%b exp=011000", {flags, reg_write, mem_write}); end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 4'h0, 2'b00, 32'h0, 2'b00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tick();
        test_reset();
        test_subs_beq();
        test_failed_cond();
        test_partial_write();
        test_stall_flush();
        test_never();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
